// File: rtl/regfile_pkg.sv
// Shared register-file definitions: geometry, the hard-wired zero register,
// and index/data types used by the bank, the issue stage and the write arbiter.
package regfile_pkg;

  localparam int AW       = 5;
  localparam int DW       = 32;
  localparam int NREG     = 1 << AW;
  localparam int ZERO_REG = 0;

  typedef logic [AW-1:0] reg_idx_t;
  typedef logic [DW-1:0] reg_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request arbiter: purely combinational. Searches from the
// supplied pointer upward (wrapping) and grants the first requester found.
// The pointer itself is owned and advanced by the instantiating module.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o
);

  int   idx;
  logic found;

  // One-hot grant to the first requester at or after the pointer
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_i) + k) % NREQ;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register bank's single write port between NREQ writeback
// sources. A round-robin arbiter picks one source per cycle; the winning
// address/data are registered onto rf_regwrite/rf_wa/rf_wd one cycle later.
// A one-bit-per-register busy scoreboard tracks reserved-but-unwritten
// destinations for the issue stage, and err_waw latches any reservation of
// a register that is still busy (issue is expected to stall on busy).
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = regfile_pkg::AW,
  parameter int DW   = regfile_pkg::DW,
  parameter int NREG = regfile_pkg::NREG
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      gnt,
  input  logic                 rsv_valid,
  input  logic [AW-1:0]        rsv_addr,
  output logic                 rf_regwrite,
  output logic [AW-1:0]        rf_wa,
  output logic [DW-1:0]        rf_wd,
  output logic [NREG-1:0]      busy,
  output logic                 err_waw
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_raw;

  logic            any_gnt;
  logic [PW-1:0]   sel_idx;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  logic            regwrite_d, regwrite_q;
  logic [AW-1:0]   wa_d, wa_q;
  logic [DW-1:0]   wd_d, wd_q;

  logic [NREG-1:0] busy_d, busy_q;
  logic            err_d, err_q;
  logic            rsv_set;
  logic            wr_clr_same;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (gnt_raw)
  );

  // A grant is only meaningful when the block is out of reset
  assign gnt = rst_n ? gnt_raw : '0;

  // Pick the winning slice and compute the next round-robin pointer
  always_comb begin
    any_gnt  = 1'b0;
    sel_idx  = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        any_gnt  = 1'b1;
        sel_idx  = PW'(i);
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
    ptr_d = ptr_q;
    if (any_gnt) begin
      ptr_d = (sel_idx == PW'(NREQ-1)) ? '0 : sel_idx + PW'(1);
    end
  end

  // Output stage: a grant to the zero register is consumed but never written
  always_comb begin
    regwrite_d = any_gnt && (sel_addr != AW'(ZERO_REG));
    wa_d       = any_gnt ? sel_addr : wa_q;
    wd_d       = any_gnt ? sel_data : wd_q;
  end

  // Scoreboard: a reservation and a committing write to the same register
  // on one edge leave it busy, and that case is not a WAW hazard
  always_comb begin
    rsv_set     = rsv_valid && (rsv_addr != AW'(ZERO_REG));
    wr_clr_same = regwrite_q && (wa_q == rsv_addr);
    busy_d      = busy_q;
    if (regwrite_q) begin
      busy_d[wa_q] = 1'b0;
    end
    if (rsv_set) begin
      busy_d[rsv_addr] = 1'b1;
    end
    err_d = err_q | (rsv_set && busy_q[rsv_addr] && !wr_clr_same);
  end

  // All state; reset also drops any write in flight to the bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      regwrite_q <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
      busy_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      regwrite_q <= regwrite_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign rf_regwrite = regwrite_q;
  assign rf_wa       = wa_q;
  assign rf_wd       = wd_q;
  assign busy        = busy_q;
  assign err_waw     = err_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: table of arbitration vectors with a
// queue of expected bank writes, plus hand sequences for the scoreboard,
// WAW flag and asynchronous reset.
module tb_regfile_write_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic              rsv_valid;
  logic [AW-1:0]     rsv_addr;
  logic              rf_regwrite;
  logic [AW-1:0]     rf_wa;
  logic [DW-1:0]     rf_wd;
  logic [NREG-1:0]   busy;
  logic              err_waw;

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .NREQ (NREQ),
    .AW   (AW),
    .DW   (DW),
    .NREG (NREG)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .gnt         (gnt),
    .rsv_valid   (rsv_valid),
    .rsv_addr    (rsv_addr),
    .rf_regwrite (rf_regwrite),
    .rf_wa       (rf_wa),
    .rf_wd       (rf_wd),
    .busy        (busy),
    .err_waw     (err_waw)
  );

  typedef struct {
    logic [1:0]  req;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  exp_gnt;
  } vec_t;

  typedef struct {
    logic        rw;
    logic [4:0]  wa;
    logic [31:0] wd;
  } exp_t;

  exp_t q[$];
  vec_t vecs[11];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] r, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    req      = r;
    req_addr = {a1, a0};
    req_data = {d1, d0};
  endtask

  task automatic push_exp(input logic [1:0] g, input logic [4:0] a0, input logic [4:0] a1,
                          input logic [31:0] d0, input logic [31:0] d1);
    exp_t e;
    e.rw = 1'b0; e.wa = '0; e.wd = '0;
    if (g[0]) begin
      e.rw = (a0 != 5'd0); e.wa = a0; e.wd = d0;
    end else if (g[1]) begin
      e.rw = (a1 != 5'd0); e.wa = a1; e.wd = d1;
    end
    q.push_back(e);
  endtask

  task automatic pop_chk(input string nm);
    exp_t e;
    if (q.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = q.pop_front();
      chk({nm, ".rw"}, 64'(rf_regwrite), 64'(e.rw));
      if (e.rw) begin
        chk({nm, ".wa"}, 64'(rf_wa), 64'(e.wa));
        chk({nm, ".wd"}, 64'(rf_wd), 64'(e.wd));
      end
    end
  endtask

  initial begin
    // req, a0, a1, d0, d1, expected grant (pointer starts at 0 after reset)
    vecs[0]  = '{2'b01, 5'd5, 5'd0, 32'hDEAD_BEEF, 32'h0,   2'b01}; // single, ptr->1
    vecs[1]  = '{2'b10, 5'd0, 5'd7, 32'h0,         32'h77,  2'b10}; // single, ptr->0
    vecs[2]  = '{2'b11, 5'd1, 5'd2, 32'h11,        32'h22,  2'b01}; // contention
    vecs[3]  = '{2'b11, 5'd4, 5'd2, 32'h44,        32'h22,  2'b10};
    vecs[4]  = '{2'b11, 5'd4, 5'd6, 32'h44,        32'h66,  2'b01};
    vecs[5]  = '{2'b11, 5'd8, 5'd6, 32'h88,        32'h66,  2'b10}; // ptr->0
    vecs[6]  = '{2'b10, 5'd0, 5'd0, 32'h0,         32'h7,   2'b10}; // zero reg, ptr->0
    vecs[7]  = '{2'b00, 5'd3, 5'd3, 32'h1,         32'h2,   2'b00}; // idle
    vecs[8]  = '{2'b10, 5'd0, 5'd10, 32'h0,        32'hA0,  2'b10}; // search skips 0
    vecs[9]  = '{2'b01, 5'd11, 5'd0, 32'hB0,       32'h0,   2'b01}; // ptr->1
    vecs[10] = '{2'b01, 5'd12, 5'd0, 32'hC0,       32'h0,   2'b01}; // wraps to 0

    rst_n = 1'b0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    drive(2'b11, 5'd1, 5'd2, 32'h1, 32'h2);

    // Reset state with both requesters asserting
    repeat (3) @(negedge clk);
    chk("rst.gnt", 64'(gnt), 64'd0);
    chk("rst.rw", 64'(rf_regwrite), 64'd0);
    chk("rst.wa", 64'(rf_wa), 64'd0);
    chk("rst.wd", 64'(rf_wd), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.err", 64'(err_waw), 64'd0);
    rst_n = 1'b1;

    // Table-driven arbitration and output stage
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].req, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
      #1;
      chk($sformatf("vec%0d.gnt", i), 64'(gnt), 64'(vecs[i].exp_gnt));
      push_exp(vecs[i].exp_gnt, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
      @(negedge clk);
      pop_chk($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.busy", i), 64'(busy), 64'd0);
    end

    // Scoreboard: reserve 9, write 9, re-reserve on the committing edge
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    @(negedge clk);
    rsv_valid = 1'b0;
    chk("sb.busy9", 64'(busy), 64'(32'h1 << 9));
    chk("sb.err0", 64'(err_waw), 64'd0);
    drive(2'b01, 5'd9, 5'd0, 32'h9999, 32'h0);
    #1;
    chk("sb.gnt", 64'(gnt), 64'd1);
    push_exp(2'b01, 5'd9, 5'd0, 32'h9999, 32'h0);
    @(negedge clk);
    pop_chk("sb.wr9");
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    @(negedge clk);
    rsv_valid = 1'b0;
    chk("sb.setwins", 64'(busy), 64'(32'h1 << 9));
    chk("sb.noerr", 64'(err_waw), 64'd0);
    drive(2'b01, 5'd9, 5'd0, 32'h1234, 32'h0);
    @(negedge clk);
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    chk("sb.wr9b", 64'(rf_regwrite), 64'd1);
    @(negedge clk);
    chk("sb.clear", 64'(busy), 64'd0);
    chk("hold.rw", 64'(rf_regwrite), 64'd0);
    chk("hold.wa", 64'(rf_wa), 64'd9);
    chk("hold.wd", 64'(rf_wd), 64'h1234);

    // WAW: reserve 3 twice with no intervening write
    rsv_valid = 1'b1; rsv_addr = 5'd3;
    @(negedge clk);
    @(negedge clk);
    rsv_valid = 1'b0;
    chk("waw.err", 64'(err_waw), 64'd1);
    chk("waw.busy", 64'(busy), 64'(32'h1 << 3));
    @(negedge clk);
    chk("waw.sticky", 64'(err_waw), 64'd1);

    // Asynchronous reset while a write is on the bank port
    drive(2'b01, 5'd3, 5'd0, 32'h55, 32'h0);
    @(negedge clk);
    chk("ar.pre", 64'(rf_regwrite), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.rw", 64'(rf_regwrite), 64'd0);
    chk("ar.wa", 64'(rf_wa), 64'd0);
    chk("ar.wd", 64'(rf_wd), 64'd0);
    chk("ar.busy", 64'(busy), 64'd0);
    chk("ar.err", 64'(err_waw), 64'd0);
    chk("ar.gnt", 64'(gnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b11, 5'd3, 5'd4, 32'h55, 32'h66);
    #1;
    chk("ar.ptr0", 64'(gnt), 64'd1);
    @(negedge clk);
    chk("ar.rw2", 64'(rf_regwrite), 64'd1);
    chk("ar.wa2", 64'(rf_wa), 64'd3);
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
